bounded_integrator: RTL and testbench

BOUNDED_INTEGRATOR -- requirements
Module: bounded_integrator

---
 rtl/bounded_integrator_if.sv | 31 +++
 rtl/bounded_integrator.sv | 60 ++++++
 tb/tb_bounded_integrator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bounded_integrator_if.sv
// Stream bus for the bounded integrator.
// Carries the input sample beat and the windowed-sum output beat.
interface bounded_integrator_if #(
  parameter int WIDTH = 8,
  parameter int G     = 3
);
  logic [WIDTH-1:0]   i_tdata;
  logic               i_tvalid;
  logic               i_tready;
  logic [WIDTH+G-1:0] o_tdata;
  logic               o_tvalid;
  logic               o_tready;

  modport slave (
    input  i_tdata,
    input  i_tvalid,
    output i_tready,
    output o_tdata,
    output o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata,
    output i_tvalid,
    input  i_tready,
    input  o_tdata,
    input  o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/bounded_integrator.sv
// Sliding-window sum of the last SIZE signed samples.
// Circular history plus a running accumulator that doubles as the output register.
module bounded_integrator #(
  parameter int WIDTH                = 8,
  parameter int SIZE                 = 6,
  parameter int LogTow_SIZE_PlusOne  = 3
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clear,
  bounded_integrator_if.slave  bus
);
  localparam int G  = LogTow_SIZE_PlusOne;
  localparam int OW = WIDTH + G;
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [WIDTH-1:0] r_hist [SIZE];
  logic [PW-1:0]    r_ptr;
  logic [OW-1:0]    r_acc;
  logic             r_valid;

  logic             w_accept;
  logic [PW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_old;
  logic [OW-1:0]    w_new_ext;
  logic [OW-1:0]    w_old_ext;
  logic [OW-1:0]    w_sum;

  assign bus.i_tready = bus.o_tready | ~r_valid;
  assign bus.o_tvalid = r_valid;
  assign bus.o_tdata  = r_acc;

  assign w_accept = bus.i_tvalid & bus.i_tready;

  assign w_ptr_nxt = (r_ptr == PW'(SIZE - 1)) ? '0 : r_ptr + 1'b1;

  // Slot under the pointer holds the oldest sample, about to be evicted.
  assign w_old     = r_hist[r_ptr];
  assign w_new_ext = {{G{bus.i_tdata[WIDTH-1]}}, bus.i_tdata};
  assign w_old_ext = {{G{w_old[WIDTH-1]}}, w_old};
  assign w_sum     = r_acc + w_new_ext - w_old_ext;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_accept) begin
      r_hist[r_ptr] <= bus.i_tdata;
      r_ptr         <= w_ptr_nxt;
      r_acc         <= w_sum;
      r_valid       <= 1'b1;
    end else if (bus.o_tready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bounded_integrator.sv
// Randomised scoreboard bench for bounded_integrator.
// Reference keeps the accepted samples in a queue and sums the tail.
module tb_bounded_integrator;
  localparam int WIDTH = 8;
  localparam int SIZE  = 6;
  localparam int G     = 3;

  logic clk;
  logic reset;
  logic clear;

  bounded_integrator_if #(.WIDTH(WIDTH), .G(G)) bus ();

  bounded_integrator #(
    .WIDTH(WIDTH),
    .SIZE(SIZE),
    .LogTow_SIZE_PlusOne(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int hist [$];
  int sb   [$];
  bit exp_valid = 1'b0;
  int exp_cur   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected sum per output handshake.
  always @(negedge clk) begin
    if (bus.o_tvalid === 1'b1 && bus.o_tready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got %0d expected none at %0t",
                 $signed(bus.o_tdata), $time);
      end else begin
        chk("o_tdata_sb", $signed(bus.o_tdata), sb.pop_front());
      end
    end
  end

  function automatic int window_sum();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  // One clock: drive, check visible state, then advance the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy,
                       input bit clr, input bit rst, output bit acc);
    bit er;
    @(posedge clk);
    #1;
    bus.i_tvalid = v;
    bus.i_tdata  = d;
    bus.o_tready = rdy;
    clear        = clr;
    reset        = rst;
    #5;
    er = rdy | ~exp_valid;
    chk("i_tready", {31'd0, bus.i_tready}, {31'd0, er});
    chk("o_tvalid", {31'd0, bus.o_tvalid}, {31'd0, exp_valid});
    chk("o_tdata_hold", $signed(bus.o_tdata), exp_cur);
    acc = v & er & ~clr & ~rst;
    if (rst || clr) begin
      hist.delete();
      sb.delete();
      exp_valid = 1'b0;
      exp_cur   = 0;
    end else if (acc) begin
      logic signed [7:0] sd;
      sd = d;
      hist.push_back(int'(sd));
      if (hist.size() > SIZE) void'(hist.pop_front());
      exp_cur   = window_sum();
      exp_valid = 1'b1;
      sb.push_back(exp_cur);
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic beat(input logic [7:0] d);
    bit a;
    int guard = 0;
    a = 1'b0;
    while (!a && guard < 8) begin
      cycle(1'b1, d, 1'b1, 1'b0, 1'b0, a);
      guard++;
    end
    if (!a) chk("beat_accept", 0, 1);
  endtask

  task automatic idle(input bit rdy, input bit clr, input bit rst);
    bit a;
    cycle(1'b0, 8'h00, rdy, clr, rst, a);
  endtask

  initial begin
    bit a;
    int k;
    int n;
    reset        = 1'b1;
    clear        = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.o_tready = 1'b1;

    // Reset held: outputs zero/invalid, ready high.
    repeat (3) idle(1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 1'b0);

    // Alternating extremes.
    for (int i = 0; i < 14; i++) beat((i % 2 == 0) ? 8'h7F : 8'h80);

    // Constant max then constant min.
    idle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) beat(8'h7F);
    for (int i = 0; i < 10; i++) beat(8'h80);
    idle(1'b1, 1'b0, 1'b0);

    // Clear after three beats, with a beat presented that must be dropped.
    idle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) beat(8'h7F);
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, a);
    idle(1'b1, 1'b0, 1'b0);
    beat(8'h01);

    // Ramp with a five-cycle downstream stall in the middle.
    idle(1'b1, 1'b0, 1'b1);
    k = 0;
    n = 0;
    while (k < 400 && n < 2000) begin
      bit rdy;
      rdy = !(n >= 100 && n < 105);
      cycle(1'b1, k[7:0], rdy, 1'b0, 1'b0, a);
      if (a) k++;
      n++;
    end
    chk("ramp_done", k, 400);

    // Reset mid-stream with valid high, then a single min sample.
    for (int i = 0; i < 4; i++) beat(8'h33);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, a);
    beat(8'h80);

    // Random traffic with back-pressure, clears and resets.
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit rdy;
      bit clr;
      bit rst;
      logic [7:0] d;
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 4) != 0;
      clr = ($urandom % 60) == 0;
      rst = ($urandom % 97) == 0;
      d   = 8'($urandom);
      cycle(v, d, rdy, clr, rst, a);
    end

    // Drain.
    repeat (3) idle(1'b1, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
